// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back data select, register-file write port,
// forwarding bus and a retired-instruction counter.
module mem_wb_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid_M,
    input  logic [31:0]      PC_M,
    input  logic [31:0]      ALUResult_M,
    input  logic [31:0]      memRD_M,
    input  logic             regWrite_M,
    input  logic [4:0]       A3_M,
    input  logic [1:0]       WDSel_M,
    output logic             regWE,
    output logic [4:0]       regA3,
    output logic [31:0]      regWD,
    output logic [31:0]      WBBack,
    output logic [31:0]      PC_W,
    output logic             valid_W,
    output logic [CNT_W-1:0] retire_cnt
);

    logic             valid_r;
    logic [31:0]      pc_r;
    logic [31:0]      alu_result_r;
    logic [31:0]      mem_rd_r;
    logic             reg_write_r;
    logic [4:0]       a3_r;
    logic [1:0]       wd_sel_r;
    logic [CNT_W-1:0] retire_cnt_r;
    logic             retire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r      <= 1'b0;
            pc_r         <= RESET_PC;
            alu_result_r <= 32'h0;
            mem_rd_r     <= 32'h0;
            reg_write_r  <= 1'b0;
            a3_r         <= 5'd0;
            wd_sel_r     <= 2'b00;
        end else if (flush) begin
            valid_r      <= 1'b0;
            pc_r         <= RESET_PC;
            alu_result_r <= 32'h0;
            mem_rd_r     <= 32'h0;
            reg_write_r  <= 1'b0;
            a3_r         <= 5'd0;
            wd_sel_r     <= 2'b00;
        end else if (!stall) begin
            valid_r      <= valid_M;
            pc_r         <= PC_M;
            alu_result_r <= ALUResult_M;
            mem_rd_r     <= memRD_M;
            // Bubbles must never write the register file.
            reg_write_r  <= regWrite_M & valid_M;
            a3_r         <= A3_M;
            wd_sel_r     <= WDSel_M;
        end
    end

    // A flush still lets the current valid instruction leave WB, even if stall is also high.
    assign retire = valid_r & (flush | ~stall);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt_r <= '0;
        end else if (retire) begin
            retire_cnt_r <= retire_cnt_r + 1'b1;
        end
    end

    always_comb begin
        regWD = 32'h0;
        case (wd_sel_r)
            2'b00:   regWD = alu_result_r;
            2'b01:   regWD = mem_rd_r;
            2'b10:   regWD = pc_r + 32'd8;
            default: regWD = 32'h0;
        endcase
    end

    assign regWE      = reg_write_r & valid_r & (a3_r != 5'd0);
    assign regA3      = a3_r;
    assign WBBack     = regWD;
    assign PC_W       = pc_r;
    assign valid_W    = valid_r;
    assign retire_cnt = retire_cnt_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, hand-written stall/flush/reset
// sequences and randomized traffic against a write-back-level reference model.
module tb_mem_wb_stage;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        valid_M;
    logic [31:0] PC_M;
    logic [31:0] ALUResult_M;
    logic [31:0] memRD_M;
    logic        regWrite_M;
    logic [4:0]  A3_M;
    logic [1:0]  WDSel_M;

    logic        regWE;
    logic [4:0]  regA3;
    logic [31:0] regWD;
    logic [31:0] WBBack;
    logic [31:0] PC_W;
    logic        valid_W;
    logic [31:0] retire_cnt;

    logic        regWE4;
    logic [4:0]  regA3_4;
    logic [31:0] regWD4;
    logic [31:0] WBBack4;
    logic [31:0] PC_W4;
    logic        valid_W4;
    logic [3:0]  retire_cnt4;

    mem_wb_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_M(valid_M),
        .PC_M(PC_M), .ALUResult_M(ALUResult_M), .memRD_M(memRD_M), .regWrite_M(regWrite_M),
        .A3_M(A3_M), .WDSel_M(WDSel_M), .regWE(regWE), .regA3(regA3), .regWD(regWD),
        .WBBack(WBBack), .PC_W(PC_W), .valid_W(valid_W), .retire_cnt(retire_cnt)
    );

    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_M(valid_M),
        .PC_M(PC_M), .ALUResult_M(ALUResult_M), .memRD_M(memRD_M), .regWrite_M(regWrite_M),
        .A3_M(A3_M), .WDSel_M(WDSel_M), .regWE(regWE4), .regA3(regA3_4), .regWD(regWD4),
        .WBBack(WBBack4), .PC_W(PC_W4), .valid_W(valid_W4), .retire_cnt(retire_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model holds the architecturally visible write-back record, not the raw pipeline fields.
    logic        m_valid;
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        rw;
        logic [4:0]  a3;
        logic [1:0]  sel;
        logic        e_we;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_we    = 1'b0;
        m_a3    = 5'd0;
        m_wd    = 32'h0;
        m_pc    = RST_PC;
        m_cnt   = 32'h0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".regWE"},   {31'h0, regWE},   {31'h0, m_we});
        check({tag, ".regA3"},   {27'h0, regA3},   {27'h0, m_a3});
        check({tag, ".regWD"},   regWD,            m_wd);
        check({tag, ".WBBack"},  WBBack,           m_wd);
        check({tag, ".PC_W"},    PC_W,             m_pc);
        check({tag, ".valid_W"}, {31'h0, valid_W}, {31'h0, m_valid});
        check({tag, ".cnt"},     retire_cnt,       m_cnt);
        check({tag, ".cnt4"},    {28'h0, retire_cnt4}, {28'h0, m_cnt[3:0]});
    endtask

    // One clock edge: predict from the inputs currently driven, then compare #1 after the edge.
    task automatic step();
        logic        n_valid, n_we;
        logic [4:0]  n_a3;
        logic [31:0] n_wd, n_pc, n_cnt;
        n_valid = m_valid; n_we = m_we; n_a3 = m_a3; n_wd = m_wd; n_pc = m_pc; n_cnt = m_cnt;
        if (flush) begin
            n_cnt   = m_cnt + {31'h0, m_valid};
            n_valid = 1'b0; n_we = 1'b0; n_a3 = 5'd0; n_wd = 32'h0; n_pc = RST_PC;
        end else if (!stall) begin
            n_cnt   = m_cnt + {31'h0, m_valid};
            n_valid = valid_M;
            n_we    = valid_M && regWrite_M && (A3_M != 5'd0);
            n_a3    = A3_M;
            n_pc    = PC_M;
            if (WDSel_M == 2'd0)      n_wd = ALUResult_M;
            else if (WDSel_M == 2'd1) n_wd = memRD_M;
            else if (WDSel_M == 2'd2) n_wd = PC_M + 32'd8;
            else                      n_wd = 32'h0;
        end
        @(posedge clk);
        #1;
        m_valid = n_valid; m_we = n_we; m_a3 = n_a3; m_wd = n_wd; m_pc = n_pc; m_cnt = n_cnt;
    endtask

    task automatic drive_random();
        valid_M     = ($urandom_range(0, 3) != 0);
        PC_M        = $urandom;
        ALUResult_M = $urandom;
        memRD_M     = $urandom;
        regWrite_M  = $urandom_range(0, 1) == 1;
        A3_M        = 5'($urandom_range(0, 31));
        WDSel_M     = 2'($urandom_range(0, 3));
    endtask

    task automatic drive_vec(input vec_t v);
        valid_M = v.v; PC_M = v.pc; ALUResult_M = v.alu; memRD_M = v.mem;
        regWrite_M = v.rw; A3_M = v.a3; WDSel_M = v.sel;
    endtask

    initial begin
        logic [31:0] snap_wd, snap_pc, snap_cnt;
        vecs[0] = '{1'b1, 32'h0000_3000, 32'h1234_5678, 32'h0, 1'b1, 5'd8,  2'd0, 1'b1, 32'h1234_5678};
        vecs[1] = '{1'b1, 32'h0000_3004, 32'h0,  32'hDEAD_BEEF, 1'b1, 5'd9, 2'd1, 1'b1, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h0000_3010, 32'h1,  32'h2, 1'b1, 5'd31, 2'd2, 1'b1, 32'h0000_3018};
        vecs[3] = '{1'b1, 32'h0000_3014, 32'h5,  32'h6, 1'b1, 5'd3,  2'd3, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'h9,  32'h9, 1'b1, 5'd31, 2'd2, 1'b1, 32'h0000_0004};
        vecs[5] = '{1'b1, 32'h0000_3020, 32'hAAAA, 32'h0, 1'b1, 5'd0, 2'd0, 1'b0, 32'h0000_AAAA};
        vecs[6] = '{1'b0, 32'h0000_3024, 32'h77, 32'h0, 1'b1, 5'd5,  2'd0, 1'b0, 32'h0000_0077};
        vecs[7] = '{1'b1, 32'h0000_3028, 32'h0,  32'h55, 1'b0, 5'd7, 2'd1, 1'b0, 32'h0000_0055};

        // Reset held with random inputs toggling.
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive_random();
            @(posedge clk);
            #1;
            check_all("reset");
        end
        @(negedge clk);
        reset = 1'b1;

        // Directed vectors; all independent of prior contents since no stall/flush.
        for (int i = 0; i < 8; i++) begin
            drive_vec(vecs[i]);
            step();
            check($sformatf("vec%0d.regWE", i), {31'h0, regWE}, {31'h0, vecs[i].e_we});
            check($sformatf("vec%0d.regA3", i), {27'h0, regA3}, {27'h0, vecs[i].a3});
            check($sformatf("vec%0d.regWD", i), regWD, vecs[i].e_wd);
            check($sformatf("vec%0d.WBBack", i), WBBack, vecs[i].e_wd);
            check($sformatf("vec%0d.PC_W", i), PC_W, vecs[i].pc);
            check($sformatf("vec%0d.valid_W", i), {31'h0, valid_W}, {31'h0, vecs[i].v});
            check($sformatf("vec%0d.cnt", i), retire_cnt, (i == 7) ? 32'd6 : i);
            check_all($sformatf("vec%0d", i));
        end

        // Stall for 3 cycles with changing inputs: everything frozen.
        drive_vec(vecs[0]);
        step();
        snap_wd = regWD; snap_pc = PC_W; snap_cnt = retire_cnt;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            step();
            check("stall.wd", regWD, snap_wd);
            check("stall.pc", PC_W, snap_pc);
            check("stall.cnt", retire_cnt, snap_cnt);
            check_all("stall");
        end

        // Stall and flush together: bubble loaded, departing instruction counted.
        flush = 1'b1;
        drive_random();
        step();
        check("sflush.valid", {31'h0, valid_W}, 32'h0);
        check("sflush.we", {31'h0, regWE}, 32'h0);
        check("sflush.pc", PC_W, RST_PC);
        check("sflush.cnt", retire_cnt, snap_cnt + 32'd1);
        check_all("sflush");
        stall = 1'b0; flush = 1'b0;

        // Asynchronous reset between edges while a write is pending.
        drive_vec(vecs[0]);
        step();
        check("arst.pre_we", {31'h0, regWE}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("arst.we", {31'h0, regWE}, 32'h0);
        check("arst.cnt", retire_cnt, 32'h0);
        check_all("arst");
        @(negedge clk);
        check_all("arst_hold");
        reset = 1'b1;

        // 16 retires wrap the 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            drive_vec(vecs[0]);
            step();
        end
        check("wrap.cnt4", {28'h0, retire_cnt4}, 32'h0);
        check("wrap.cnt", retire_cnt, 32'd16);
        check_all("wrap");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive_random();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            step();
            check_all("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
